// File: rtl/l1_addr_ctrl.sv
// rtl/l1_addr_ctrl.sv - L1 event buffer write/read address controller
module l1_addr_ctrl #(
    parameter int ADDRWIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dis,
    input  logic                 l1a,
    input  logic                 rdReq,
    output logic [ADDRWIDTH-1:0] wrAddr,
    output logic                 wren,
    output logic [ADDRWIDTH-1:0] rdAddr,
    output logic                 preLoad,
    output logic                 load,
    output logic                 full,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   occupancy,
    output logic [7:0]           overflowCnt
);

    localparam int DEPTH = 1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH:0] DEPTH_V = (ADDRWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRELOAD = 2'd1,
        LOAD    = 2'd2
    } rdState_t;

    rdState_t             rdState;
    logic [ADDRWIDTH:0]   wp;
    logic [ADDRWIDTH:0]   rp;
    logic [ADDRWIDTH:0]   wpNext;
    logic [ADDRWIDTH:0]   rpNext;
    logic [ADDRWIDTH:0]   occNext;
    logic                 wrAcc;
    logic                 wrRej;
    logic                 rdAcc;

    // Extra pointer MSB separates a full buffer from an empty one
    assign occupancy = wp - rp;

    // Request acceptance uses the pre-edge full/empty flags; a read cannot
    // start while a preLoad is still owed its load, even if dis froze it
    always_comb begin
        wrAcc   = l1a & ~dis & ~full;
        wrRej   = l1a & ~dis & full;
        rdAcc   = rdReq & ~dis & ~empty & (rdState != PRELOAD);
        wpNext  = wp + (ADDRWIDTH+1)'(wrAcc);
        rpNext  = rp + (ADDRWIDTH+1)'(rdAcc);
        occNext = wpNext - rpNext;
    end

    // Pointers, flags, overflow counter and read sequencer with registered pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp          <= '0;
            rp          <= '0;
            wrAddr      <= '0;
            rdAddr      <= '0;
            wren        <= 1'b0;
            preLoad     <= 1'b0;
            load        <= 1'b0;
            full        <= 1'b0;
            empty       <= 1'b1;
            overflowCnt <= '0;
            rdState     <= IDLE;
        end else if (dis) begin
            wren    <= 1'b0;
            preLoad <= 1'b0;
            load    <= 1'b0;
        end else begin
            wren <= wrAcc;
            if (wrAcc) begin
                wrAddr <= wp[ADDRWIDTH-1:0];
            end
            wp <= wpNext;
            if (wrRej && overflowCnt != 8'hFF) begin
                overflowCnt <= overflowCnt + 8'd1;
            end
            if (rdAcc) begin
                rdAddr <= rp[ADDRWIDTH-1:0];
            end
            rp    <= rpNext;
            full  <= (occNext == DEPTH_V);
            empty <= (occNext == '0);

            preLoad <= rdAcc;
            load    <= (rdState == PRELOAD);
            if (rdAcc) begin
                rdState <= PRELOAD;
            end else if (rdState == PRELOAD) begin
                rdState <= LOAD;
            end else begin
                rdState <= IDLE;
            end
        end
    end

endmodule
